sha256d_header_feeder: RTL

Host-side driver for the team's SHA256 block core: accepts an 80-byte Bitcoin block header and performs a complete double SHA-256 (SHA256d) over it. It builds the padded message blocks, sequences the core's start / blk_type / blk_done handshake across both passes, and returns the final 256-bit digest. It sits between the mining/header-assembly logic and the SHA256 core instance, and is the sole driver of the core's inputs.

---
 rtl/sha256d_header_feeder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/sha256d_header_feeder.sv
// ---------------------------------------------------------------------------
// sha256d_header_feeder
//
// Drives a SHA256 block core through a complete double SHA-256 of an 80-byte
// block header. Pass 1 sends the header as a two-block HEADER job. The second
// block is the header tail followed by padding and the 640-bit length. Pass 2
// sends the 256-bit pass-1 digest as a single padded HASH block. The pass-2
// result is presented on digest.
//
// Ports
//   CLK            clock, rising edge
//   nreset         asynchronous active-low reset (shared with the core)
//   hdr_valid      header request; taken when hdr_valid && hdr_ready
//   header[639:0]  header bytes, first byte in [639:632]
//   hdr_ready      request can be accepted this cycle
//   busy           a header is being hashed (accept .. digest_valid)
//   digest[255:0]  SHA256(SHA256(header)), H0 in [255:224], held
//   digest_valid   one-cycle pulse when digest updates
//   core_start     one-cycle start pulse to the core
//   core_msg[511:0] message block to the core, W0 in [511:480]
//   core_blk_type  0 = HASH (one block), 2 = HEADER (two blocks)
//   core_hash[255:0] core result, valid while core_blk_done is high
//   core_blk_done  core pulse at the end of each block
// ---------------------------------------------------------------------------
module sha256d_header_feeder (
  input  logic         CLK,
  input  logic         nreset,
  input  logic         hdr_valid,
  input  logic [639:0] header,
  output logic         hdr_ready,
  output logic         busy,
  output logic [255:0] digest,
  output logic         digest_valid,
  output logic         core_start,
  output logic [511:0] core_msg,
  output logic [1:0]   core_blk_type,
  input  logic [255:0] core_hash,
  input  logic         core_blk_done
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    P1_B1 = 3'd1,
    P1_B2 = 3'd2,
    P2    = 3'd3,
    OUT   = 3'd4
  } state_t;

  localparam logic [1:0]  BLK_HASH   = 2'd0;
  localparam logic [1:0]  BLK_HEADER = 2'd2;
  // Big-endian bit counts placed in the final 64 bits of each padded message.
  localparam logic [63:0] HDR_BITS   = 64'd640;
  localparam logic [63:0] DIG_BITS   = 64'd256;

  state_t         state_reg,  state_next;
  logic [639:0]   hdr_reg,    hdr_next;
  logic [511:0]   msg_reg,    msg_next;
  logic [1:0]     type_reg,   type_next;
  logic           start_reg,  start_next;
  logic [255:0]   digest_reg, digest_next;

  logic           accept;

  // OUT also accepts a request. This lets a held hdr_valid start the next
  // header on the edge that ends the digest_valid cycle.
  assign hdr_ready    = (state_reg == IDLE) || (state_reg == OUT);
  assign busy         = (state_reg == P1_B1) || (state_reg == P1_B2) ||
                        (state_reg == P2);
  assign digest_valid = (state_reg == OUT);
  assign accept       = hdr_valid && hdr_ready;

  assign digest        = digest_reg;
  assign core_start    = start_reg;
  assign core_msg      = msg_reg;
  assign core_blk_type = type_reg;

  always_ff @(posedge CLK or negedge nreset) begin
    if (!nreset) begin
      state_reg  <= IDLE;
      hdr_reg    <= '0;
      msg_reg    <= '0;
      type_reg   <= BLK_HASH;
      start_reg  <= 1'b0;
      digest_reg <= '0;
    end else begin
      state_reg  <= state_next;
      hdr_reg    <= hdr_next;
      msg_reg    <= msg_next;
      type_reg   <= type_next;
      start_reg  <= start_next;
      digest_reg <= digest_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    hdr_next    = hdr_reg;
    msg_next    = msg_reg;
    type_next   = type_reg;
    start_next  = 1'b0;            // start is only ever a single-cycle pulse
    digest_next = digest_reg;

    case (state_reg)
      // A core_blk_done seen here is a protocol error and is ignored.
      IDLE, OUT: begin
        if (accept) begin
          hdr_next   = header;
          msg_next   = header[639:128];
          type_next  = BLK_HEADER;
          start_next = 1'b1;
          state_next = P1_B1;
        end else begin
          state_next = IDLE;
        end
      end

      // The core picks up block 2 two edges after raising blk_done. It is
      // registered on the first of those edges, so it is stable in time.
      P1_B1: begin
        if (core_blk_done) begin
          msg_next   = {hdr_reg[127:0], 8'h80, {312{1'b0}}, HDR_BITS};
          state_next = P1_B2;
        end
      end

      P1_B2: begin
        if (core_blk_done) begin
          msg_next   = {core_hash, 8'h80, {184{1'b0}}, DIG_BITS};
          type_next  = BLK_HASH;
          start_next = 1'b1;
          state_next = P2;
        end
      end

      P2: begin
        if (core_blk_done) begin
          digest_next = core_hash;
          state_next  = OUT;
        end
      end

      default: state_next = IDLE;
    endcase
  end

endmodule
